// File: rtl/mux4to1_cond_sync.sv
// Four-lane selector with a same-cycle output and a registered copy.
// sel_chg flags a change of the captured select for one cycle.
module mux4to1_cond_sync #(
    parameter int WIDTH   = 1,
    parameter int RST_VAL = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [4*WIDTH-1:0]   in_c,
    input  logic [1:0]           sel_c,
    input  logic                 en,
    output logic [WIDTH-1:0]     out_c,
    output logic [WIDTH-1:0]     out_q,
    output logic                 sel_chg
);

    localparam logic [WIDTH-1:0] RST_Q = WIDTH'(RST_VAL);

    logic [WIDTH-1:0] lane0;
    logic [WIDTH-1:0] lane1;
    logic [WIDTH-1:0] lane2;
    logic [WIDTH-1:0] lane3;
    logic [1:0]       sel_q;

    assign lane0 = in_c[0*WIDTH +: WIDTH];
    assign lane1 = in_c[1*WIDTH +: WIDTH];
    assign lane2 = in_c[2*WIDTH +: WIDTH];
    assign lane3 = in_c[3*WIDTH +: WIDTH];

    // Nested ?: keeps X-merging behaviour on unknown select bits.
    assign out_c = sel_c[1] ? (sel_c[0] ? lane3 : lane2)
                            : (sel_c[0] ? lane1 : lane0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q   <= RST_Q;
            sel_q   <= 2'b00;
            sel_chg <= 1'b0;
        end else begin
            sel_chg <= en & (sel_c != sel_q);
            if (en) begin
                out_q <= out_c;
                sel_q <= sel_c;
            end
        end
    end

endmodule

// File: tb/tb_mux4to1_cond_sync.sv
// Bench for mux4to1_cond_sync: WIDTH=1 and WIDTH=4 instances driven in lockstep
// against a lane-extraction reference model.
module tb_mux4to1_cond_sync;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  in1;
    logic [15:0] in4;
    logic [1:0]  sel;
    logic        en;
    logic        out_c1, out_q1, chg1;
    logic [3:0]  out_c4, out_q4;
    logic        chg4;

    int vectors = 0;
    int miscompares = 0;

    // reference state
    logic [3:0]  eq1;
    logic [3:0]  eq4;
    logic [1:0]  esel;
    logic        echg;

    always #5 clk = ~clk;

    mux4to1_cond_sync #(.WIDTH(1), .RST_VAL(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_c(in1), .sel_c(sel), .en(en),
        .out_c(out_c1), .out_q(out_q1), .sel_chg(chg1)
    );

    mux4to1_cond_sync #(.WIDTH(4), .RST_VAL(0)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_c(in4), .sel_c(sel), .en(en),
        .out_c(out_c4), .out_q(out_q4), .sel_chg(chg4)
    );

    function automatic logic [3:0] lane(input logic [15:0] din, input int s, input int w);
        logic [15:0] v;
        v = (din >> (s * w)) & ((16'd1 << w) - 16'd1);
        return v[3:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        eq1  = 4'd0;
        eq4  = 4'd0;
        esel = 2'b00;
        echg = 1'b0;
    endtask

    task automatic check_comb(input string tag);
        check({tag, "_c1"}, {31'd0, out_c1}, {28'd0, lane({12'd0, in1}, int'(sel), 1)});
        check({tag, "_c4"}, {28'd0, out_c4}, {28'd0, lane(in4, int'(sel), 4)});
    endtask

    task automatic check_regs(input string tag);
        check({tag, "_q1"},   {31'd0, out_q1}, {28'd0, eq1});
        check({tag, "_chg1"}, {31'd0, chg1},   {31'd0, echg});
        check({tag, "_q4"},   {28'd0, out_q4}, {28'd0, eq4});
        check({tag, "_chg4"}, {31'd0, chg4},   {31'd0, echg});
    endtask

    // One clock edge: advance the model from the current inputs, then sample.
    task automatic tick(input string tag);
        if (en) begin
            eq1  = lane({12'd0, in1}, int'(sel), 1);
            eq4  = lane(in4, int'(sel), 4);
            echg = (sel != esel);
            esel = sel;
        end else begin
            echg = 1'b0;
        end
        @(posedge clk);
        #1;
        check_regs(tag);
    endtask

    logic [3:0] exp_bits [4];
    logic [3:0] exp_nib  [4];

    initial begin
        exp_bits = '{4'd0, 4'd1, 4'd0, 4'd1};
        exp_nib  = '{4'hA, 4'hB, 4'hC, 4'hD};
        rst_n = 1'b0;
        en    = 1'b0;
        sel   = 2'b00;
        in1   = 4'b1010;
        in4   = 16'hDCBA;
        model_reset();
        #2;
        check_regs("reset");

        // combinational selection, no clock edge needed
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s);
            #1;
            check("comb_w1_const", {31'd0, out_c1}, {28'd0, exp_bits[s]});
            check("comb_w4_const", {28'd0, out_c4}, {28'd0, exp_nib[s]});
        end

        @(negedge clk);
        rst_n = 1'b1;

        // registered path, one edge latency
        en = 1'b1;
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s);
            tick("load_step");
            check("load_w1_const", {31'd0, out_q1}, {28'd0, exp_bits[s]});
        end

        // enable low holds out_q and suppresses sel_chg
        sel = 2'b00;
        tick("hold_setup");
        en  = 1'b0;
        sel = 2'b01;
        tick("hold_1");
        tick("hold_2");
        check("hold_q_const", {31'd0, out_q1}, 32'd0);

        // asynchronous reset mid-stream
        en  = 1'b1;
        sel = 2'b01;
        tick("pre_rst");
        check("pre_rst_q_const", {31'd0, out_q1}, 32'd1);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_regs("async_rst");
        sel = 2'b11;
        #1;
        check_comb("rst_comb_11");
        sel = 2'b10;
        #1;
        check_comb("rst_comb_10");
        @(negedge clk);
        rst_n = 1'b1;

        // sel_chg pulses for one cycle per change
        sel = 2'b01;
        tick("chg_a");
        sel = 2'b11;
        tick("chg_b");
        check("chg_pulse_const", {31'd0, chg1}, 32'd1);
        tick("chg_hold");
        check("chg_clear_const", {31'd0, chg1}, 32'd0);

        // randomized traffic
        for (int i = 0; i < 300; i++) begin
            in1 = 4'($urandom);
            in4 = 16'($urandom);
            sel = 2'($urandom_range(0, 3));
            en  = ($urandom_range(0, 3) != 0);
            #1;
            check_comb("rand");
            tick("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
